fmac_adders_pipe: RTL and testbench
===================================

# fmac_adders_pipe

Pipelined, width-parametrised successor of the FMAC end-around-carry adder stage. It sits between the carry-save multiplier/aligner and the LZA/normaliser. It forms the positive magnitude of the low sum and carry using parallel uninverted and inverted carry-select adders plus a high-part incrementer/decrementer, and produces the result sign and the LZA operands. Unlike the single-cycle version, it registers its work, carries a valid/ready handshake with back-pressure, accepts a flush, and passes a tag through.

## Interface
- `C_MANT`, default 23: mantissa width. Derived widths: `WL = 2*C_MANT+2`, `WH = C_MANT+4`, `WO = 3*C_MANT+5`.
- `C_TAG`, default 4: width of the sideband tag carried with each operation.
- Clock and reset: one clock; reset is synchronous and active-low, named `Clk_CI` and `Rst_RBI` as elsewhere in the codebase.
- `Clk_CI` in 1: clock, rising edge.
- `Rst_RBI` in 1: synchronous active-low reset.
- `In_valid_SI` in 1; `In_ready_SO` out 1: input handshake.
- `AL_DI` in WL: low carry-save sum.
- `BL_DI` in WL: low carry-save carry.
- `BH_DI` in WH: aligned high addend.
- `Sub_SI` in 1: effective subtraction.
- `Sign_cor_SI` in 3: sign-correction bits.
- `Sign_amt_DI` in 1: addend dominates (alignment saturated).
- `Sft_stop_SI` in 1: addend fully shifted out.
- `Sign_postalig_DI` in 1: sign after alignment.
- `Tag_DI` in C_TAG: opaque sideband.
- `Flush_SI` in 1: kill all in-flight operations.
- `Out_valid_SO` out 1; `Out_ready_SI` in 1: output handshake.
- `Sum_pos_DO` out WO: positive magnitude.
- `Sign_out_DO` out 1: result sign.
- `A_LZA_DO` out WO; `B_LZA_DO` out WO: LZA operands.
- `Tag_DO` out C_TAG: tag of the current output.

## Operation
- Stage 1 (S1) captures inputs and computes the low adders.
- `Cpc = Sign_amt ? 0 : (~|Sign_cor) ^ BL[WL-1]`.
- `{Cu,Su[WL-1:0]} = {0,AL} + {Cpc, BL[WL-2:0], Sub}`.
- `{Ci,Si[WL:0]} = ({1,~AL,1} + {~Cpc, ~BL[WL-2:0], 2'b11} + 2)`, truncated to WL+2 bits.
- S1 registers `Cu, Su, Ci, Si, BH`, the controls and the tag. Adders are computed from the inputs, not from registered values.
- Stage 2 (S2) computes the high part and the output selection:
  - `Hu = Cu ? BH+1 : BH` and `Hi = Ci ? ~BH : ~BH-1`, both WH bits, carry-out dropped.
  - `Sum_pos = Sft_stop ? {0, Su}`, zero-extended to WO.
  - Otherwise, if `Sign_amt`: `Sum_pos = {BH[WH-2:0], WL'b0}`.
  - Otherwise, if `Hu[WH-1]`: `Sum_pos = {Hi[WH-2:0], Si[WL:1]}`.
  - Otherwise: `Sum_pos = {Hu[WH-2:0], Su}`.
  - `Sign_out = Sign_amt ? Sign_postalig : Hu[WH-1] ^ Sign_postalig`.
  - `A_LZA = {BH[WH-2:0], WL'b0}` unconditionally.
  - `B_LZA = Sign_amt ? 0 : {0, Cu, Su}`, zero-extended.
- Each stage holds one valid bit. A stage loads when it is empty or its content is moving downstream this cycle.
- `In_ready_SO = ~S1_valid | S1_advance`. This is combinational from `Out_ready_SI` through the chain and has no dependence on `In_valid_SI`.
- An output is held stable, data and tag included, while `Out_valid_SO & ~Out_ready_SI`.
- Flush:
  - `Flush_SI` clears all valid bits at the next edge.
  - An input presented in the same cycle is dropped.
  - `In_ready_SO` is forced to 1 during flush.
- Simultaneous push and pop on a full pipe: both occur with no bubble, so full throughput is 1 op/cycle.
- Reset clears all valid bits and all data registers to 0. After reset, all outputs are 0, including `Out_valid_SO`.

## Timing
- With `FMAC_ADDERS_OUTREG_EN` the latency is 2 cycles (input edge to `Out_valid_SO`) and the pipe holds 2 ops.
- Without it the latency is 1 cycle and the pipe holds 1 op.
- Reset and flush take effect at the first rising edge with `Rst_RBI=0` or `Flush_SI=1`. Reset has priority over flush, which has priority over load.
- Data registers load only on handshake; they carry no enable on idle cycles.

## Configuration
- `FMAC_ADDERS_OUTREG_EN` defined: S2 results go through a second register stage with its own valid bit. Outputs are driven directly from flops.
- Not defined: S2 logic is combinational from the S1 registers and the outputs come from that logic.
- The handshake rules are identical in both builds.

## Test plan
- `C_MANT=23`, `Sft_stop=1`, `Sign_amt=1`, `AL=5`, `BL=3`, `Sub=0`, `Sign_postalig=1` -> `Sum_pos=0xB`, `Sign_out=1`, `B_LZA=0`, `A_LZA={BH[25:0],48'b0}`.
- `Sft_stop=0`, `Sign_amt=1`, `BH=1` -> `Sum_pos=A_LZA=1<<48`, `Sign_out=Sign_postalig`.
- `Sign_amt=0`, `Sign_cor=1`, `AL=BL=0`, `Sub=1`, `BH=0` -> `Sum_pos=1`, `B_LZA=1`, `Sign_out=Sign_postalig`. Same inputs with `BH=0x4000000` -> inverted path taken, `Sign_out=~Sign_postalig`.
- Back-pressure: issue 3 ops with `Out_ready=0`.
  - `In_ready` drops after 2 accepted (1 without the macro).
  - Output stays stable.
  - Raising `Out_ready` drains the ops in order with tags 1, 2, 3 at 1/cycle.
- Flush with 2 ops in flight plus one input -> `Out_valid=0` next cycle, and no stale tag appears later.
- `Rst_RBI=0` for 1 cycle mid-stream -> all outputs 0 and `In_ready=1` next cycle. The first op after reset completes at the nominal latency.

Source files
------------

// File: rtl/fmac_adders_pipe.sv
// fmac_adders_pipe
//
// Pipelined FMAC end-around-carry adder stage. Sits between the carry-save
// multiplier/aligner and the LZA/normaliser. The low carry-save pair is summed
// by parallel uninverted and inverted adders in stage 1. Stage 2 builds the
// high-part increment/decrement, picks the positive magnitude, derives the
// result sign and forms the LZA operands. A valid/ready handshake with
// back-pressure, a flush and a pass-through tag travel with each operation.
//
// Build option: define FMAC_ADDERS_OUTREG_EN to register the stage-2 results.
// That gives 2-cycle latency and 2 ops in flight. Without it, stage 2 is
// combinational from the stage-1 flops: 1-cycle latency and 1 op in flight.
//
// Ports (WL = 2*C_MANT+2, WH = C_MANT+4, WO = 3*C_MANT+5):
//   Clk_CI, Rst_RBI           clock (rising edge), synchronous active-low reset
//   In_valid_SI/In_ready_SO   input handshake
//   AL_DI, BL_DI [WL]         low carry-save sum / carry
//   BH_DI [WH]                aligned high addend
//   Sub_SI, Sign_cor_SI[3]    effective subtraction, sign-correction bits
//   Sign_amt_DI, Sft_stop_SI  addend dominates / addend fully shifted out
//   Sign_postalig_DI          sign after alignment
//   Tag_DI [C_TAG]            opaque sideband, returned on Tag_DO
//   Flush_SI                  kill everything in flight
//   Out_valid_SO/Out_ready_SI output handshake
//   Sum_pos_DO [WO]           positive magnitude
//   Sign_out_DO               result sign
//   A_LZA_DO, B_LZA_DO [WO]   LZA operands
//   Tag_DO [C_TAG]            tag of the current output

module fmac_adders_pipe #(
    parameter int unsigned C_MANT = 23,
    parameter int unsigned C_TAG  = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  In_valid_SI,
    output logic                  In_ready_SO,
    input  logic [2*C_MANT+1:0]   AL_DI,
    input  logic [2*C_MANT+1:0]   BL_DI,
    input  logic [C_MANT+3:0]     BH_DI,
    input  logic                  Sub_SI,
    input  logic [2:0]            Sign_cor_SI,
    input  logic                  Sign_amt_DI,
    input  logic                  Sft_stop_SI,
    input  logic                  Sign_postalig_DI,
    input  logic [C_TAG-1:0]      Tag_DI,
    input  logic                  Flush_SI,
    output logic                  Out_valid_SO,
    input  logic                  Out_ready_SI,
    output logic [3*C_MANT+4:0]   Sum_pos_DO,
    output logic                  Sign_out_DO,
    output logic [3*C_MANT+4:0]   A_LZA_DO,
    output logic [3*C_MANT+4:0]   B_LZA_DO,
    output logic [C_TAG-1:0]      Tag_DO
);

    localparam int unsigned WL = 2*C_MANT+2;
    localparam int unsigned WH = C_MANT+4;
    localparam int unsigned WO = 3*C_MANT+5;

    // ------------------------------------------------------------------
    // Stage 1: low adders, computed straight from the inputs
    // ------------------------------------------------------------------
    logic          w_cpc;
    logic [WL:0]   w_sum_u;
    logic [WL+1:0] w_sum_i;
    logic          w_unused_si0;

    assign w_cpc   = Sign_amt_DI ? 1'b0 : ((~|Sign_cor_SI) ^ BL_DI[WL-1]);
    assign w_sum_u = {1'b0, AL_DI} + {w_cpc, BL_DI[WL-2:0], Sub_SI};
    // Inverted adder; the sum is taken modulo 2^(WL+2)
    assign w_sum_i = {1'b1, ~AL_DI, 1'b1} + {~w_cpc, ~BL_DI[WL-2:0], 2'b11}
                   + {{WL{1'b0}}, 2'b10};
    // Si[0] never reaches an output
    assign w_unused_si0 = w_sum_i[0];

    logic             r_s1_valid;
    logic             r_s1_cu;
    logic [WL-1:0]    r_s1_su;
    logic             r_s1_ci;
    logic [WL-1:0]    r_s1_si;     // Si[WL:1]
    logic [WH-1:0]    r_s1_bh;
    logic             r_s1_sft_stop;
    logic             r_s1_sign_amt;
    logic             r_s1_sign_postalig;
    logic [C_TAG-1:0] r_s1_tag;

    logic w_s1_load;
    logic w_s1_advance;

    assign In_ready_SO = ~r_s1_valid | w_s1_advance | Flush_SI;
    assign w_s1_load   = In_valid_SI & In_ready_SO & ~Flush_SI;

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_s1_valid <= 1'b0;
        end else if (Flush_SI) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_s1_cu            <= 1'b0;
            r_s1_su            <= '0;
            r_s1_ci            <= 1'b0;
            r_s1_si            <= '0;
            r_s1_bh            <= '0;
            r_s1_sft_stop      <= 1'b0;
            r_s1_sign_amt      <= 1'b0;
            r_s1_sign_postalig <= 1'b0;
            r_s1_tag           <= '0;
        end else if (w_s1_load) begin
            r_s1_cu            <= w_sum_u[WL];
            r_s1_su            <= w_sum_u[WL-1:0];
            r_s1_ci            <= w_sum_i[WL+1];
            r_s1_si            <= w_sum_i[WL:1];
            r_s1_bh            <= BH_DI;
            r_s1_sft_stop      <= Sft_stop_SI;
            r_s1_sign_amt      <= Sign_amt_DI;
            r_s1_sign_postalig <= Sign_postalig_DI;
            r_s1_tag           <= Tag_DI;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: high part and output selection, from the stage-1 flops
    // ------------------------------------------------------------------
    logic [WH-1:0] w_hu;
    logic [WH-1:0] w_hi;
    logic          w_unused_hi_msb;
    logic [WO-1:0] w_sum_pos;
    logic          w_sign_out;
    logic [WO-1:0] w_a_lza;
    logic [WO-1:0] w_b_lza;

    assign w_hu = r_s1_cu ? (r_s1_bh + WH'(1)) : r_s1_bh;
    assign w_hi = r_s1_ci ? ~r_s1_bh : (~r_s1_bh - WH'(1));
    assign w_unused_hi_msb = w_hi[WH-1];

    always_comb begin
        w_sum_pos = '0;
        if (r_s1_sft_stop) begin
            w_sum_pos = {{(WO-WL){1'b0}}, r_s1_su};
        end else if (r_s1_sign_amt) begin
            w_sum_pos = {r_s1_bh[WH-2:0], {WL{1'b0}}};
        end else if (w_hu[WH-1]) begin
            // High part went negative: take the inverted-path magnitude
            w_sum_pos = {w_hi[WH-2:0], r_s1_si};
        end else begin
            w_sum_pos = {w_hu[WH-2:0], r_s1_su};
        end
    end

    assign w_sign_out = r_s1_sign_amt ? r_s1_sign_postalig
                                      : (w_hu[WH-1] ^ r_s1_sign_postalig);
    assign w_a_lza    = {r_s1_bh[WH-2:0], {WL{1'b0}}};
    assign w_b_lza    = r_s1_sign_amt ? '0
                                      : {{(WO-WL-1){1'b0}}, r_s1_cu, r_s1_su};

`ifdef FMAC_ADDERS_OUTREG_EN
    logic             r_s2_valid;
    logic [WO-1:0]    r_s2_sum_pos;
    logic             r_s2_sign_out;
    logic [WO-1:0]    r_s2_a_lza;
    logic [WO-1:0]    r_s2_b_lza;
    logic [C_TAG-1:0] r_s2_tag;
    logic             w_s2_advance;

    assign w_s2_advance = r_s2_valid & Out_ready_SI;
    assign w_s1_advance = r_s1_valid & (~r_s2_valid | Out_ready_SI);

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_s2_valid <= 1'b0;
        end else if (Flush_SI) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_advance) begin
            r_s2_valid <= 1'b1;
        end else if (w_s2_advance) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_s2_sum_pos  <= '0;
            r_s2_sign_out <= 1'b0;
            r_s2_a_lza    <= '0;
            r_s2_b_lza    <= '0;
            r_s2_tag      <= '0;
        end else if (w_s1_advance && !Flush_SI) begin
            r_s2_sum_pos  <= w_sum_pos;
            r_s2_sign_out <= w_sign_out;
            r_s2_a_lza    <= w_a_lza;
            r_s2_b_lza    <= w_b_lza;
            r_s2_tag      <= r_s1_tag;
        end
    end

    assign Out_valid_SO = r_s2_valid;
    assign Sum_pos_DO   = r_s2_sum_pos;
    assign Sign_out_DO  = r_s2_sign_out;
    assign A_LZA_DO     = r_s2_a_lza;
    assign B_LZA_DO     = r_s2_b_lza;
    assign Tag_DO       = r_s2_tag;
`else
    assign w_s1_advance = r_s1_valid & Out_ready_SI;

    assign Out_valid_SO = r_s1_valid;
    assign Sum_pos_DO   = w_sum_pos;
    assign Sign_out_DO  = w_sign_out;
    assign A_LZA_DO     = w_a_lza;
    assign B_LZA_DO     = w_b_lza;
    assign Tag_DO       = r_s1_tag;
`endif

endmodule

// File: tb/tb_fmac_adders_pipe.sv
// Directed testbench for fmac_adders_pipe (C_MANT=23, C_TAG=4).
module tb_fmac_adders_pipe;

`ifdef FMAC_ADDERS_OUTREG_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] al;
    logic [47:0] bl;
    logic [26:0] bh;
    logic        sub;
    logic [2:0]  sign_cor;
    logic        sign_amt;
    logic        sft_stop;
    logic        sign_post;
    logic [3:0]  tag_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [73:0] sum_pos;
    logic        sign_out;
    logic [73:0] a_lza;
    logic [73:0] b_lza;
    logic [3:0]  tag_out;

    int n_tests = 0;
    int n_fail  = 0;

    fmac_adders_pipe #(.C_MANT(23), .C_TAG(4)) dut (
        .Clk_CI           (clk),
        .Rst_RBI          (rst_n),
        .In_valid_SI      (in_valid),
        .In_ready_SO      (in_ready),
        .AL_DI            (al),
        .BL_DI            (bl),
        .BH_DI            (bh),
        .Sub_SI           (sub),
        .Sign_cor_SI      (sign_cor),
        .Sign_amt_DI      (sign_amt),
        .Sft_stop_SI      (sft_stop),
        .Sign_postalig_DI (sign_post),
        .Tag_DI           (tag_in),
        .Flush_SI         (flush),
        .Out_valid_SO     (out_valid),
        .Out_ready_SI     (out_ready),
        .Sum_pos_DO       (sum_pos),
        .Sign_out_DO      (sign_out),
        .A_LZA_DO         (a_lza),
        .B_LZA_DO         (b_lza),
        .Tag_DO           (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [47:0] a, input logic [47:0] b, input logic [26:0] h,
                          input logic s, input logic [2:0] cor, input logic amt,
                          input logic stop, input logic post, input logic [3:0] t);
        al = a; bl = b; bh = h; sub = s; sign_cor = cor;
        sign_amt = amt; sft_stop = stop; sign_post = post; tag_in = t;
    endtask

    // One op into an empty pipe with Out_ready=1; check at nominal latency.
    task automatic run_op(input string name, input logic [73:0] e_sum, input logic e_sign,
                          input logic [73:0] e_a, input logic [73:0] e_b, input logic [3:0] e_tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, ".in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            chk({name, ".early_valid"}, out_valid, 1'b0);
            tick();
        end
        chk({name, ".valid"}, out_valid, 1'b1);
        chk({name, ".sum_pos"}, sum_pos, e_sum);
        chk({name, ".sign_out"}, sign_out, e_sign);
        chk({name, ".a_lza"}, a_lza, e_a);
        chk({name, ".b_lza"}, b_lza, e_b);
        chk({name, ".tag"}, tag_out, e_tag);
        tick();
        chk({name, ".popped"}, out_valid, 1'b0);
    endtask

    initial begin : main
        int n_acc;
        int exp_tag;
        int first_c;
        int last_c;
        logic acc;

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(48'h0, 48'h0, 27'h0, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        tick();
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.sum_pos", sum_pos, 74'h0);
        chk("rst.sign_out", sign_out, 1'b0);
        chk("rst.a_lza", a_lza, 74'h0);
        chk("rst.b_lza", b_lza, 74'h0);
        chk("rst.tag", tag_out, 4'h0);
        rst_n = 1'b1;
        tick();

        // Shifted-out addend: low sum only (5 + (3<<1) = 0xB)
        set_in(48'h5, 48'h3, 27'h5A5A5A5, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 4'h1);
        run_op("sftstop", 74'hB, 1'b1, {26'h1A5A5A5, 48'h0}, 74'h0, 4'h1);

        // Addend dominates: magnitude is the shifted addend
        set_in(48'h123, 48'h456, 27'h1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 4'h2);
        run_op("amt", {26'h1, 48'h0}, 1'b0, {26'h1, 48'h0}, 74'h0, 4'h2);

        // Uninverted path
        set_in(48'h0, 48'h0, 27'h0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 4'h3);
        run_op("upath", 74'h1, 1'b1, 74'h0, 74'h1, 4'h3);

        // High part negative: inverted path, sign flipped
        set_in(48'h0, 48'h0, 27'h4000000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 4'h4);
        run_op("ipath", {26'h3FFFFFE, 48'h0}, 1'b0, 74'h0, 74'h1, 4'h4);

        // Low carry-out increments the high part (5 -> 6)
        set_in(48'hFFFF_FFFF_FFFF, 48'h0, 27'h5, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 4'h5);
        run_op("carry", {26'h6, 48'h0}, 1'b0, {26'h5, 48'h0}, {25'h0, 1'b1, 48'h0}, 4'h5);

        // Back-pressure: 3 ops with Out_ready low; op k carries AL = 16*k
        out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (n_acc < 3);
            set_in(48'(16 * (n_acc + 1)), 48'h0, 27'h0, 1'b0, 3'b0, 1'b1, 1'b1, 1'b0,
                   4'(n_acc + 1));
            #1;
            acc = in_ready & in_valid;
            tick();
            if (acc) n_acc++;
        end
        chk("bp.accepted", n_acc, DEPTH);
        #1;
        chk("bp.in_ready_low", in_ready, 1'b0);
        chk("bp.valid", out_valid, 1'b1);
        chk("bp.hold_tag", tag_out, 4'h1);
        chk("bp.hold_sum", sum_pos, 74'h10);
        tick();
        chk("bp.hold_tag2", tag_out, 4'h1);
        chk("bp.hold_sum2", sum_pos, 74'h10);

        // Drain: expect tags 1,2,3 on consecutive cycles
        out_ready = 1'b1;
        exp_tag = 1;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (n_acc < 3);
            set_in(48'(16 * (n_acc + 1)), 48'h0, 27'h0, 1'b0, 3'b0, 1'b1, 1'b1, 1'b0,
                   4'(n_acc + 1));
            #1;
            if (out_valid) begin
                chk("drain.tag", tag_out, 4'(exp_tag));
                chk("drain.sum", sum_pos, 74'(16 * exp_tag));
                if (first_c < 0) first_c = c;
                last_c = c;
                exp_tag++;
            end
            acc = in_ready & in_valid;
            tick();
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
        chk("drain.count", exp_tag, 4);
        chk("drain.no_bubble", last_c - first_c, 2);

        // Flush with a full pipe plus an input in the same cycle
        out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            set_in(48'h1, 48'h0, 27'h0, 1'b0, 3'b0, 1'b1, 1'b1, 1'b0, 4'(4 + n_acc));
            #1;
            acc = in_ready;
            tick();
            if (acc) n_acc++;
        end
        chk("flush.filled", n_acc, DEPTH);
        flush = 1'b1;
        tag_in = 4'h9;
        #1;
        chk("flush.in_ready", in_ready, 1'b1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush.out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("flush.no_stale", out_valid, 1'b0);
        end

        // Reset mid-stream
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            set_in(48'h7, 48'h1, 27'h3, 1'b0, 3'b0, 1'b0, 1'b1, 1'b1, 4'(c + 1));
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mrst.out_valid", out_valid, 1'b0);
        chk("mrst.in_ready", in_ready, 1'b1);
        chk("mrst.sum_pos", sum_pos, 74'h0);
        chk("mrst.sign_out", sign_out, 1'b0);
        chk("mrst.a_lza", a_lza, 74'h0);
        chk("mrst.b_lza", b_lza, 74'h0);
        chk("mrst.tag", tag_out, 4'h0);
        set_in(48'h5, 48'h3, 27'h5A5A5A5, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 4'h7);
        run_op("postrst", 74'hB, 1'b1, {26'h1A5A5A5, 48'h0}, 74'h0, 4'h7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
